// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store initiator.
// Covers the access-size codes, the FSM state type and the request legality check.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Illegal size counts as misaligned so a single flag covers every early rejection.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response channel and memory-side request/read channel.
// Each interface has master/slave modports.
interface lsu_core_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_data_align.sv
// Combinational byte-lane logic: store mask and data replication, and load extraction.
// Also performs sign/zero extension of the extracted load data.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_lane,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_off,
  input  logic        rd_unsigned,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_ext
);

  logic [31:0] rd_shift_s;

  assign rd_shift_s = rd_word >> {rd_off, 3'b000};

  // Store side: mask shifted to the addressed lane, data replicated across lanes.
  always_comb begin
    wr_mask = 4'b0000;
    wr_lane = 32'h0000_0000;
    case (wr_size)
      SZ_B: begin
        wr_mask = 4'b0001 << wr_off;
        wr_lane = {4{wr_data[7:0]}};
      end
      SZ_H: begin
        wr_mask = 4'b0011 << wr_off;
        wr_lane = {2{wr_data[15:0]}};
      end
      SZ_W: begin
        wr_mask = 4'b1111;
        wr_lane = wr_data;
      end
      default: begin
        wr_mask = 4'b0000;
        wr_lane = 32'h0000_0000;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0 and extend.
  always_comb begin
    rd_ext = 32'h0000_0000;
    case (rd_size)
      SZ_B: begin
        if (rd_unsigned) rd_ext = {24'h00_0000, rd_shift_s[7:0]};
        else             rd_ext = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
      end
      SZ_H: begin
        if (rd_unsigned) rd_ext = {16'h0000, rd_shift_s[15:0]};
        else             rd_ext = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
      end
      SZ_W:    rd_ext = rd_shift_s;
      default: rd_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator between the core execute stage and data memory.
// Holds the FSM, the request registers and the WAIT timeout counter; all outputs are registered.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic      clock,
  input  logic      reset,
  lsu_core_if.slave core,
  lsu_mem_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic              wen_r, unsigned_r;
  logic [1:0]        size_r, off_r;
  logic              req_ready_r, resp_valid_r, resp_err_r;
  logic [31:0]       resp_rdata_r;
  logic              mem_valid_r, mem_wen_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [3:0]        mem_wmask_r;
  logic              accept_s, req_err_s, err_nxt_s, capture_s;
  logic [3:0]        wr_mask_s;
  logic [31:0]       wr_lane_s, rd_ext_s;

  lsu_data_align u_align (
    .wr_size     (core.req_size),
    .wr_off      (core.req_addr[1:0]),
    .wr_data     (core.req_wdata),
    .wr_mask     (wr_mask_s),
    .wr_lane     (wr_lane_s),
    .rd_size     (size_r),
    .rd_off      (off_r),
    .rd_unsigned (unsigned_r),
    .rd_word     (mem.mem_rdata),
    .rd_ext      (rd_ext_s)
  );

  assign accept_s  = core.req_valid && req_ready_r;
  assign req_err_s = misaligned(core.req_size, core.req_addr[1:0]);
  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Next-state, timeout counting, and response error/capture decisions.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CNT_W{1'b0}};
    err_nxt_s   = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_nxt_s = RESP;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = MEM;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEM: begin
        if (mem.mem_ready) begin
          if (wen_r) begin
            state_nxt_s = RESP;
          end else if (mem.mem_rvalid) begin
            state_nxt_s = RESP;
            capture_s   = 1'b1;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = MEM;
        end
      end
      WAIT: begin
        // Read data arriving on the final allowed cycle still wins over the timeout.
        if (mem.mem_rvalid) begin
          state_nxt_s = RESP;
          capture_s   = 1'b1;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
          state_nxt_s = RESP;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_inc_s;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request latches and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      wen_r        <= 1'b0;
      unsigned_r   <= 1'b0;
      size_r       <= 2'b00;
      off_r        <= 2'b00;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      mem_valid_r  <= 1'b0;
      mem_wen_r    <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= 32'h0000_0000;
      mem_wmask_r  <= 4'b0000;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_ready_r  <= (state_nxt_s == IDLE);
      mem_valid_r  <= (state_nxt_s == MEM);
      resp_valid_r <= (state_nxt_s == RESP);
      resp_err_r   <= (state_nxt_s == RESP) && err_nxt_s;
      if (accept_s) begin
        wen_r       <= core.req_wen;
        unsigned_r  <= core.req_unsigned;
        size_r      <= core.req_size;
        off_r       <= core.req_addr[1:0];
        mem_wen_r   <= core.req_wen;
        mem_addr_r  <= {core.req_addr[ADDR_W-1:2], 2'b00};
        mem_wdata_r <= core.req_wen ? wr_lane_s : 32'h0000_0000;
        mem_wmask_r <= core.req_wen ? wr_mask_s : 4'b0000;
      end
      if (state_nxt_s == RESP) begin
        resp_rdata_r <= capture_s ? rd_ext_s : 32'h0000_0000;
      end
    end
  end

  assign core.req_ready  = req_ready_r;
  assign core.resp_valid = resp_valid_r;
  assign core.resp_err   = resp_err_r;
  assign core.resp_rdata = resp_rdata_r;
  assign mem.mem_valid   = mem_valid_r;
  assign mem.mem_wen     = mem_wen_r;
  assign mem.mem_addr    = mem_addr_r;
  assign mem.mem_wdata   = mem_wdata_r;
  assign mem.mem_wmask   = mem_wmask_r;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that drives the core's data-memory port, the requesting end of the memory responder.
- Accepts one byte/half/word load or store per transaction from the core's execute stage over a valid/ready handshake.
- Issues a word-aligned request to memory with byte write mask and lane-shifted write data, then waits for read data.
- Returns sign/zero-extended load data or an error status to the core. Single outstanding transaction, no buffering beyond one request.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent in WAIT before the load is aborted with an error (minimum 1).
- ADDR_W, 32, address width.

Ports:
- clock  input  1  core clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-aligned
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  1 = zero-extend load result
- resp_valid  output  1  one-cycle pulse, transaction finished
- resp_rdata  output  32  extended load data (0 for stores and errors)
- resp_err  output  1  misaligned, illegal size, or timeout
- mem_valid  output  1  memory request valid
- mem_ready  input  1  memory accepts request
- mem_wen  output  1  store request
- mem_addr  output  ADDR_W  {req_addr[ADDR_W-1:2], 2'b00}
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  4  byte write mask
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  full read word

Behaviour:
- Reset (async assert, sync release) values:
  - state = IDLE, req_ready = 1.
  - resp_valid, resp_err, mem_valid, mem_wen = 0.
  - mem_addr, mem_wdata, mem_wmask, resp_rdata = 0.
  - Timeout counter = 0.
- Reset asserted mid-transaction drops mem_valid immediately and discards the transaction; no response is produced.
- FSM states: IDLE, MEM, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch all request fields.
  - Error check: req_size == 3, or half with addr[0] = 1, or word with addr[1:0] != 0 -> RESP with resp_err = 1, no memory access.
  - Otherwise -> MEM.
- MEM:
  - mem_valid = 1 with registered fields; mem_* outputs must stay stable until mem_ready.
  - On mem_ready, a store -> RESP.
  - On mem_ready, a load -> WAIT. If mem_rvalid is also high in that cycle, capture data and go directly -> RESP.
- WAIT:
  - Counter increments each cycle.
  - On mem_rvalid, capture extended data -> RESP.
  - If the counter reaches TIMEOUT_CYCLES first -> RESP with resp_err = 1, resp_rdata = 0.
  - mem_rvalid outside WAIT (and outside the MEM handshake cycle) is ignored.
- RESP:
  - resp_valid = 1 for exactly one cycle; req_ready = 0.
  - Next state IDLE; counter cleared.
- Write lane rules (o = addr[1:0]):
  - byte: mask = 4'b0001 << o, data = {4{wdata[7:0]}}.
  - half: mask = 4'b0011 << o, data = {2{wdata[15:0]}}.
  - word: mask = 4'b1111, data = wdata.
  - Loads drive mask = 0, wen = 0.
- Read extraction: lane = mem_rdata >> (8*o), then sign- or zero-extend from bit 7 (byte), bit 15 (half), or none (word) per req_unsigned.
- Latency, load with memory ready and zero-wait rvalid: accept at cycle N, MEM at N+1 (rvalid the same cycle), resp_valid at N+2.
- Latency, store: resp_valid at N+2.
- Latency, error detected in IDLE: resp_valid at N+1.
- Throughput: next request is accepted the cycle after RESP.

Decomposition:
- Package lsu_pkg holds:
  - size encoding constants SZ_B, SZ_H, SZ_W.
  - State enum {IDLE, MEM, WAIT, RESP}.
  - Function to compute the misalignment flag.
- One combinational sub-module, lsu_data_align, computes mask, write-lane replication and read extract/extend.
- The top-level holds the FSM, request registers and timeout counter.

Test Plan:
- Store byte, addr 0x80000003, wdata 0xAB, mem_ready = 1 -> mem_addr 0x80000000, mem_wmask 4'b1000, mem_wdata 0xABABABAB, resp_valid 2 cycles after accept, resp_err = 0.
- Load half signed, addr 0x80000002, mem_rdata 0x8001_1234, rvalid in the MEM cycle -> resp_rdata 0xFFFF8001. Same with req_unsigned = 1 -> 0x00008001.
- Load word, addr 0x80000001 -> no mem_valid, resp_valid next cycle, resp_err = 1, resp_rdata = 0. Repeat with req_size = 3 -> same.
- Memory backpressure: mem_ready low 5 cycles -> mem_valid and all mem_* fields held stable, req_ready = 0. Handshake completes on the 6th cycle.
- Load, mem_rvalid never asserted, TIMEOUT_CYCLES = 4 -> resp_valid with resp_err = 1 four cycles after entering WAIT. The next request is accepted normally.
- reset pulled low while in WAIT -> mem_valid = 0 and req_ready = 1 asynchronously. A later stray mem_rvalid is ignored and no resp_valid is produced.
